// File: rtl/orb_grp_dist.sv
// -----------------------------------------------------------------------------
// orb_grp_dist
//   N-channel round-robin arbiter in front of a ping-pong group buffer for the
//   Orbita frame path. One channel at a time owns the write bank and does
//   read-modify-write on DW-bit orbit words. The frame former reads the other
//   bank and swaps the two banks with a single-cycle pulse.
//
// Ports
//   clk       in   system clock
//   reset     in   asynchronous active-low reset
//   ch_busy   in   [NCH]     per-channel request, held for the whole burst
//   ch_wdata  in   [NCH*DW]  per-channel write word, channel i at [i*DW +: DW]
//   ch_waddr  in   [NCH*AW]  per-channel write address
//   ch_wren   in   [NCH]     per-channel write strobe
//   ch_raddr  in   [NCH*AW]  per-channel old-word read address
//   ch_rden   in   [NCH]     per-channel old-word read strobe
//   ch_rdata  out  [DW]      old word from the write bank (shared)
//   ch_grant  out  [NCH]     one-hot grant
//   ff_swap   in   1         exchange banks at the next edge
//   ff_raddr  in   [AW]      former read address
//   ff_rden   in   1         former read strobe
//   ff_rdata  out  [DW]      word from the read bank
//   wr_bank   out  1         index of the current write bank
//   tmo_flag  out  1         sticky: a grant was revoked by timeout
//
// Build option
//   ORB_GRP_BANKCLR_EN : when defined, every swap starts a sweeper that writes
//   zero to all 2**AW words of the new write bank, one per cycle. New grants
//   are held back until the sweep finishes; a swap during a sweep restarts it
//   in the new bank. When undefined, stale words remain after a swap.
// -----------------------------------------------------------------------------
module orb_grp_dist #(
  parameter int NCH = 5,     // requesting channels, 2..8
  parameter int DW  = 12,    // orbit word width
  parameter int AW  = 10,    // word address width per bank
  parameter int TMO = 4096   // max grant duration in cycles, >= 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    ch_busy,
  input  logic [NCH*DW-1:0] ch_wdata,
  input  logic [NCH*AW-1:0] ch_waddr,
  input  logic [NCH-1:0]    ch_wren,
  input  logic [NCH*AW-1:0] ch_raddr,
  input  logic [NCH-1:0]    ch_rden,
  output logic [DW-1:0]     ch_rdata,
  output logic [NCH-1:0]    ch_grant,
  input  logic              ff_swap,
  input  logic [AW-1:0]     ff_raddr,
  input  logic              ff_rden,
  output logic [DW-1:0]     ff_rdata,
  output logic              wr_bank,
  output logic              tmo_flag
);

  localparam int PW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW    = $clog2(TMO);
  localparam int DEPTH = 1 << AW;

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t         state;
  logic [PW-1:0]  rr_ptr;
  logic [PW-1:0]  owner;
  logic [TW-1:0]  timer;
  logic [NCH-1:0] blocked;     // channels revoked by timeout, awaiting busy low
  logic           sweep_hold;  // withholds new grants while the bank is cleared

  // ---------------------------------------------------------------------------
  // Round-robin pick: rotate the eligible vector so that bit 0 is the channel
  // at the pointer, take the lowest set bit, then map back to a channel index.
  // ---------------------------------------------------------------------------
  logic [NCH-1:0]   eligible;
  logic [2*NCH-1:0] elig_dup;
  logic [NCH-1:0]   elig_rot;
  logic [PW:0]      pick_sum;
  logic             pick_valid;
  logic [PW-1:0]    pick_idx;
  logic [PW-1:0]    next_ptr;

  // NOTE: every signal written here gets a default first so no path through
  // the block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    eligible   = ch_busy & ~blocked;
    elig_dup   = {eligible, eligible};
    elig_rot   = elig_dup[rr_ptr +: NCH];
    pick_valid = |elig_rot;
    pick_sum   = '0;
    // Descending scan so the lowest set offset is the last one written.
    for (int k = NCH - 1; k >= 0; k--) begin
      if (elig_rot[k]) pick_sum = {1'b0, rr_ptr} + (PW+1)'(k);
    end
    if (pick_sum >= (PW+1)'(NCH)) pick_idx = PW'(pick_sum - (PW+1)'(NCH));
    else                          pick_idx = PW'(pick_sum);
    next_ptr = (pick_idx == PW'(NCH - 1)) ? '0 : pick_idx + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Owner mux: only the granted channel's strobes, addresses and data reach
  // the memory; everything from other channels is ignored.
  // ---------------------------------------------------------------------------
  logic          own_wren;
  logic          own_rden;
  logic [AW-1:0] own_waddr;
  logic [AW-1:0] own_raddr;
  logic [DW-1:0] own_wdata;

  always_comb begin
    own_wren  = 1'b0;
    own_rden  = 1'b0;
    own_waddr = '0;
    own_raddr = '0;
    own_wdata = '0;
    if (state == S_GRANT) begin
      own_wren  = ch_wren[owner];
      own_rden  = ch_rden[owner];
      own_waddr = ch_waddr[owner*AW +: AW];
      own_raddr = ch_raddr[owner*AW +: AW];
      own_wdata = ch_wdata[owner*DW +: DW];
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration FSM with registered grant, timeout timer and sticky flag.
  // A grant always ends in IDLE for one cycle, so there is a dead cycle
  // between two owners.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      timer    <= '0;
      blocked  <= '0;
      ch_grant <= '0;
      tmo_flag <= 1'b0;
    end else begin
      // A revoked channel becomes eligible again once busy is seen low.
      blocked <= blocked & ch_busy;
      case (state)
        S_IDLE: begin
          timer <= '0;
          if (pick_valid && !sweep_hold) begin
            state    <= S_GRANT;
            owner    <= pick_idx;
            rr_ptr   <= next_ptr;
            ch_grant <= NCH'(1) << pick_idx;
          end
        end
        S_GRANT: begin
          if (!ch_busy[owner]) begin
            state    <= S_IDLE;
            ch_grant <= '0;
          end else if (timer == TW'(TMO - 1)) begin
            // Owner held the bank for TMO cycles: revoke and fence it off.
            state    <= S_IDLE;
            ch_grant <= '0;
            tmo_flag <= 1'b1;
            blocked  <= (blocked & ch_busy) | (NCH'(1) << owner);
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Bank select. A swap takes effect at the next edge, so any access issued in
  // the swap cycle still uses the pre-swap banks.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       wr_bank <= 1'b0;
    else if (ff_swap) wr_bank <= ~wr_bank;
  end

  // ---------------------------------------------------------------------------
  // Optional bank clear sweeper.
  // ---------------------------------------------------------------------------
`ifdef ORB_GRP_BANKCLR_EN
  logic          sweep_active;
  logic [AW-1:0] sweep_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sweep_active <= 1'b0;
      sweep_addr   <= '0;
    end else if (ff_swap) begin
      sweep_active <= 1'b1;
      sweep_addr   <= '0;
    end else if (sweep_active) begin
      if (sweep_addr == '1) sweep_active <= 1'b0;
      sweep_addr <= sweep_addr + 1'b1;
    end
  end

  assign sweep_hold = sweep_active;
`else
  assign sweep_hold = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Write port. Both banks live in one array addressed by {bank, addr}.
  // While a sweep runs it owns the write port; an owner that was granted
  // before the swap keeps its grant but its writes are dropped until the
  // sweep ends.
  // ---------------------------------------------------------------------------
  logic          mem_we;
  logic [AW:0]   mem_wa;
  logic [DW-1:0] mem_wd;

  always_comb begin
    mem_we = own_wren;
    mem_wa = {wr_bank, own_waddr};
    mem_wd = own_wdata;
`ifdef ORB_GRP_BANKCLR_EN
    if (sweep_active) begin
      mem_we = 1'b1;
      mem_wa = {wr_bank, sweep_addr};
      mem_wd = '0;
    end
`endif
  end

  logic [DW-1:0] mem [2*DEPTH];

  // NOTE: the storage array has no reset; contents survive reset and only the
  // read registers below are cleared, which keeps the array mappable to RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Registered read ports; a read and a write to the same word in one cycle
  // return the old word because the array update lands after the sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch_rdata <= '0;
      ff_rdata <= '0;
    end else begin
      if (own_rden) ch_rdata <= mem[{wr_bank, own_raddr}];
      if (ff_rden)  ff_rdata <= mem[{~wr_bank, ff_raddr}];
    end
  end

endmodule

// File: tb/tb_orb_grp_dist.sv
// -----------------------------------------------------------------------------
// tb_orb_grp_dist
//   Directed steps plus a randomized transaction phase for orb_grp_dist. The
//   reference model keeps both banks as plain arrays, tracks the round-robin
//   pointer as "last granted + 1", and predicts read data one cycle ahead.
// -----------------------------------------------------------------------------
module tb_orb_grp_dist;

  localparam int NCH = 5;
  localparam int DW  = 12;
  localparam int AW  = 10;
  localparam int TMO = 20;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    ch_busy;
  logic [NCH*DW-1:0] ch_wdata;
  logic [NCH*AW-1:0] ch_waddr;
  logic [NCH-1:0]    ch_wren;
  logic [NCH*AW-1:0] ch_raddr;
  logic [NCH-1:0]    ch_rden;
  logic [DW-1:0]     ch_rdata;
  logic [NCH-1:0]    ch_grant;
  logic              ff_swap;
  logic [AW-1:0]     ff_raddr;
  logic              ff_rden;
  logic [DW-1:0]     ff_rdata;
  logic              wr_bank;
  logic              tmo_flag;

  orb_grp_dist #(.NCH(NCH), .DW(DW), .AW(AW), .TMO(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .ch_busy  (ch_busy),
    .ch_wdata (ch_wdata),
    .ch_waddr (ch_waddr),
    .ch_wren  (ch_wren),
    .ch_raddr (ch_raddr),
    .ch_rden  (ch_rden),
    .ch_rdata (ch_rdata),
    .ch_grant (ch_grant),
    .ff_swap  (ff_swap),
    .ff_raddr (ff_raddr),
    .ff_rden  (ff_rden),
    .ff_rdata (ff_rdata),
    .wr_bank  (wr_bank),
    .tmo_flag (tmo_flag)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [DW-1:0] m_mem [2][1<<AW];
  int            m_bank;
  int            m_owner;
  int            m_ptr;
  logic [DW-1:0] m_ch_rd;
  logic [DW-1:0] m_ff_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First requester at or after the pointer, wrapping.
  function automatic int rr_pick(input logic [NCH-1:0] mask, input int ptr);
    for (int k = 0; k < NCH; k++) begin
      if (mask[(ptr + k) % NCH]) return (ptr + k) % NCH;
    end
    return -1;
  endfunction

  task automatic clear_strobes();
    ch_wren  = '0;
    ch_rden  = '0;
    ch_wdata = '0;
    ch_waddr = '0;
    ch_raddr = '0;
    ff_swap  = 1'b0;
    ff_rden  = 1'b0;
    ff_raddr = '0;
  endtask

  task automatic set_wr(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ch_wren[c]            = 1'b1;
    ch_waddr[c*AW +: AW]  = a;
    ch_wdata[c*DW +: DW]  = d;
  endtask

  task automatic set_rd(input int c, input logic [AW-1:0] a);
    ch_rden[c]           = 1'b1;
    ch_raddr[c*AW +: AW] = a;
  endtask

  // One clock: predict from the inputs now applied, then advance to just
  // after the edge where the outputs are sampled.
  task automatic step();
    int wb;
    wb = m_bank;
    if (m_owner >= 0 && ch_rden[m_owner])
      m_ch_rd = m_mem[wb][ch_raddr[m_owner*AW +: AW]];
    if (ff_rden)
      m_ff_rd = m_mem[1 - wb][ff_raddr];
    if (m_owner >= 0 && ch_wren[m_owner])
      m_mem[wb][ch_waddr[m_owner*AW +: AW]] = ch_wdata[m_owner*DW +: DW];
    if (ff_swap) m_bank = 1 - m_bank;
    @(posedge clk);
    #1;
  endtask

  task automatic acquire(input int c, input int budget);
    int n;
    n = 0;
    ch_busy[c] = 1'b1;
    do begin
      step();
      n++;
    end while (ch_grant == '0 && n < budget);
    check("acquire_grant", 32'(ch_grant), 32'(1 << c));
    m_owner = c;
    m_ptr   = (c + 1) % NCH;
  endtask

  task automatic release_owner();
    clear_strobes();
    ch_busy[m_owner] = 1'b0;
    step();
    m_owner = -1;
    check("release_grant", 32'(ch_grant), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [NCH-1:0] mask;
    int exp_c;
    int ops;

    reset   = 1'b0;
    ch_busy = '0;
    clear_strobes();
    m_bank  = 0;
    m_owner = -1;
    m_ptr   = 0;
    m_ch_rd = '0;
    m_ff_rd = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // 1: quiet after reset
    for (int i = 0; i < 100; i++) begin
      step();
      check("t1_idle", 32'({ch_grant, ch_rdata, ff_rdata, wr_bank, tmo_flag}), 32'h0);
    end

    // 2: simultaneous requests from 1 and 3, pointer at 0
    ch_busy = 5'b01010;
    step();
    check("t2_first", 32'(ch_grant), 32'b00010);
    m_owner = 1; m_ptr = 2;
    step();
    check("t2_hold", 32'(ch_grant), 32'b00010);
    ch_busy[1] = 1'b0;
    step();
    m_owner = -1;
    check("t2_dead", 32'(ch_grant), 32'h0);
    step();
    check("t2_second", 32'(ch_grant), 32'b01000);
    m_owner = 3; m_ptr = 4;
    release_owner();

    // 3: write, read back, swap, former read; a non-owner strobes alongside
    acquire(2, 4);
    set_wr(2, 10'h155, 12'hABC);
    set_wr(4, 10'h155, 12'h999);
    set_rd(4, 10'h155);
    step();
    clear_strobes();
    set_rd(2, 10'h155);
    set_wr(0, 10'h155, 12'h111);
    step();
    clear_strobes();
    check("t3_owner_read", 32'(ch_rdata), 32'hABC);
    step();
    check("t3_rdata_hold", 32'(ch_rdata), 32'hABC);
    release_owner();
    ff_swap = 1'b1;
    step();
    ff_swap = 1'b0;
    check("t3_bank", 32'(wr_bank), 32'h1);
    ff_rden = 1'b1; ff_raddr = 10'h155;
    step();
    ff_rden = 1'b0;
    check("t3_ff_read", 32'(ff_rdata), 32'hABC);

    // Preload words 0..15 in both banks so random reads have known data.
    for (int b = 0; b < 2; b++) begin
      acquire(0, 4);
      for (int a = 0; a < 16; a++) begin
        clear_strobes();
        set_wr(0, AW'(a), DW'($urandom));
        step();
      end
      release_owner();
      ff_swap = 1'b1;
      step();
      ff_swap = 1'b0;
    end

    // 5: write and swap in the same cycle; owner keeps the grant
    acquire(1, 4);
    set_wr(1, 10'h3FF, 12'h123);
    ff_swap = 1'b1;
    step();
    clear_strobes();
    check("t5_grant_kept", 32'(ch_grant), 32'b00010);
    check("t5_bank", 32'(wr_bank), 32'(m_bank));
    release_owner();
    ff_rden = 1'b1; ff_raddr = 10'h3FF;
    step();
    ff_rden = 1'b0;
    check("t5_ff_read", 32'(ff_rdata), 32'h123);

    // Randomized transactions against the model.
    for (int t = 0; t < 30; t++) begin
      mask  = NCH'($urandom_range(1, (1 << NCH) - 1));
      exp_c = rr_pick(mask, m_ptr);
      ch_busy = mask;
      step();
      check("rnd_arb", 32'(ch_grant), 32'(1 << exp_c));
      m_owner = exp_c;
      m_ptr   = (exp_c + 1) % NCH;
      ch_busy = NCH'(1 << exp_c);
      ops = $urandom_range(2, 12);
      for (int j = 0; j < ops; j++) begin
        for (int c = 0; c < NCH; c++) begin
          ch_wren[c]           = 1'($urandom_range(0, 1));
          ch_rden[c]           = 1'($urandom_range(0, 1));
          ch_waddr[c*AW +: AW] = AW'($urandom_range(0, 15));
          ch_raddr[c*AW +: AW] = AW'($urandom_range(0, 15));
          ch_wdata[c*DW +: DW] = DW'($urandom);
        end
        ff_swap  = ($urandom_range(0, 7) == 0);
        ff_rden  = 1'($urandom_range(0, 1));
        ff_raddr = AW'($urandom_range(0, 15));
        step();
        check("rnd_ch_rdata", 32'(ch_rdata), 32'(m_ch_rd));
        check("rnd_ff_rdata", 32'(ff_rdata), 32'(m_ff_rd));
        check("rnd_bank", 32'(wr_bank), 32'(m_bank));
        check("rnd_grant", 32'(ch_grant), 32'(1 << exp_c));
      end
      release_owner();
    end

    // 4: timeout revoke, pending channel served, revoked one fenced off
    check("t4_flag_clear", 32'(tmo_flag), 32'h0);
    ch_busy[1] = 1'b1;
    step();
    check("t4_grant", 32'(ch_grant), 32'b00010);
    m_owner = 1;
    ch_busy[4] = 1'b1;
    n = 1;
    while (n < 2 * TMO) begin
      step();
      if (ch_grant != 5'b00010) break;
      n++;
    end
    m_owner = -1;
    check("t4_grant_len", 32'(n), 32'(TMO));
    check("t4_revoked", 32'(ch_grant), 32'h0);
    check("t4_flag_set", 32'(tmo_flag), 32'h1);
    step();
    check("t4_other", 32'(ch_grant), 32'b10000);
    m_owner = 4;
    release_owner();
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_fenced", 32'(ch_grant), 32'h0);
    end
    ch_busy[1] = 1'b0;
    step();
    ch_busy[1] = 1'b1;
    step();
    check("t4_regrant", 32'(ch_grant), 32'b00010);
    m_owner = 1;
    release_owner();
    check("t4_flag_sticky", 32'(tmo_flag), 32'h1);

    // 6: write, swap twice, read back the same word
    acquire(3, 4);
    set_wr(3, 10'h010, 12'h777);
    step();
    release_owner();
    ff_swap = 1'b1;
    step();
    ff_swap = 1'b0;
    step();
    ff_swap = 1'b1;
    step();
    ff_swap = 1'b0;
    acquire(3, 1200);
    set_rd(3, 10'h010);
    step();
    clear_strobes();
`ifdef ORB_GRP_BANKCLR_EN
    check("t6_cleared", 32'(ch_rdata), 32'h0);
`else
    check("t6_stale", 32'(ch_rdata), 32'h777);
`endif

    // Reset in the middle of a burst drops everything at once.
    set_wr(3, 10'h020, 12'h555);
    #2 reset = 1'b0;
    #1;
    check("rst_async", 32'({ch_grant, ch_rdata, ff_rdata, wr_bank, tmo_flag}), 32'h0);
    clear_strobes();
    ch_busy = '0;
    @(negedge clk);
    reset   = 1'b1;
    m_owner = -1; m_ptr = 0; m_bank = 0; m_ch_rd = '0; m_ff_rd = '0;
    step();
    check("rst_after", 32'({ch_grant, ch_rdata, ff_rdata, wr_bank, tmo_flag}), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
